// File: rtl/uart_tx_model_if.sv
// Byte push channel into the UART transmitter model: valid/ready with one payload word.
interface uart_tx_model_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    tx_valid;
  logic                    tx_ready;
  logic [PAYLOAD_BITS-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_model.sv
// Testbench-side UART transmitter: FIFO-buffered bytes serialised as start/data/stop frames.
// state | meaning
// IDLE  | line high, waiting for a byte and uart_tx_en
// START | start bit (low) for one bit period
// DATA  | payload bits, LSB first
// STOP  | stop bit(s) high; may chain straight into the next START
module uart_tx_model #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            uart_tx_en,
  uart_tx_model_if.slave                  push,
  output logic                            uart_txd,
  output logic                            uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int CYC_W = (CPB >= 2) ? $clog2(CPB) : 1;
  localparam int BIT_W = $clog2(PAYLOAD_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (CPB < 2) begin : g_cpb_chk
    $error("uart_tx_model: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_payload_chk
    $error("uart_tx_model: PAYLOAD_BITS must be 5..8");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q;
  logic [CYC_W-1:0]        cyc_q;
  logic [BIT_W-1:0]        bit_q;
  logic [PAYLOAD_BITS-1:0] sh_q;
  logic                    txd_q;
  logic                    busy_q;

  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;

  logic ready;
  logic push_fire;
  logic bit_end;
  logic stop_end;
  logic pop;

  // Ready and pop both look only at registered count, so a push into an empty
  // FIFO is not seen by the FSM until the following cycle.
  assign ready         = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push.tx_ready = ready;
  assign push_fire     = push.tx_valid && ready;
  assign bit_end       = (cyc_q == CYC_W'(CPB - 1));
  assign stop_end      = (state_q == STOP) && bit_end && (bit_q == BIT_W'(STOP_BITS - 1));
  assign pop           = (cnt_q != '0) && uart_tx_en && ((state_q == IDLE) || stop_end);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_fire, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push.tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= START;
            cyc_q   <= '0;
            sh_q    <= mem_q[rd_ptr_q];
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            cyc_q   <= '0;
            bit_q   <= '0;
            txd_q   <= sh_q[0];
            sh_q    <= sh_q >> 1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == BIT_W'(PAYLOAD_BITS - 1)) begin
              state_q <= STOP;
              bit_q   <= '0;
              txd_q   <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
              txd_q <= sh_q[0];
              sh_q  <= sh_q >> 1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
              bit_q <= '0;
              if (pop) begin
                state_q <= START;
                sh_q    <= mem_q[rd_ptr_q];
                txd_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign fifo_count   = cnt_q;
endmodule

// File: tb/tb_uart_tx_model.sv
// Directed bench for uart_tx_model at CPB=10: waveform, loopback decode, FIFO full, enable and reset cases.
module tb_uart_tx_model;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en1, en2;
  logic       txd1, busy1, txd2, busy2;
  logic [4:0] cnt1, cnt2;

  uart_tx_model_if #(.PAYLOAD_BITS(8)) if1 ();
  uart_tx_model_if #(.PAYLOAD_BITS(8)) if2 ();

  uart_tx_model #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .reset(reset), .uart_tx_en(en1), .push(if1),
    .uart_txd(txd1), .uart_tx_busy(busy1), .fifo_count(cnt1));

  uart_tx_model #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
    .clk(clk), .reset(reset), .uart_tx_en(en2), .push(if2),
    .uart_txd(txd2), .uart_tx_busy(busy2), .fifo_count(cnt2));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Loopback receiver on dut1's line: mid-bit sampling at CPB=10.
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         rx_ferr = 0;
  string      rx_line = "";
  logic [7:0] rx_b;
  always begin
    @(negedge clk);
    if (!reset && txd1 === 1'b0) begin
      start_q.push_back(cyc);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        rx_b[i] = txd1;
      end
      repeat (10) @(negedge clk);
      if (txd1 !== 1'b1) rx_ferr++;
      rx_q.push_back(rx_b);
      if (rx_b == 8'h0A) begin
        $display("TB_UART :%s", rx_line);
        rx_line = "";
      end else begin
        rx_line = $sformatf("%s%c", rx_line, rx_b);
      end
    end
  end

  logic [7:0] pq[$];
  task automatic push_pq();
    foreach (pq[i]) begin
      @(negedge clk);
      if1.tx_valid = 1'b1;
      if1.tx_data  = pq[i];
    end
    @(negedge clk);
    if1.tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_rx_timeout"}, 32'(rx_q.size() >= n), 1);
  endtask

  // Called at the negedge following the push edge; checks every cycle of the frame.
  task automatic check_frame(input string tag, input bit sel, input logic [7:0] d, input int nstop);
    int   len = (9 + nstop) * 10;
    logic e;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k < 10)      e = 1'b0;
      else if (k < 90) e = d[(k - 10) / 10];
      else             e = 1'b1;
      chk($sformatf("%s_txd_c%0d", tag, k + 1), 32'(sel ? txd2 : txd1), 32'(e));
      chk($sformatf("%s_busy_c%0d", tag, k + 1), 32'(sel ? busy2 : busy1), 1);
    end
    @(negedge clk);
    chk({tag, "_busy_end"}, 32'(sel ? busy2 : busy1), 0);
    chk({tag, "_txd_end"}, 32'(sel ? txd2 : txd1), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    reset = 1'b1;
    en1 = 1'b0;
    en2 = 1'b0;
    if1.tx_valid = 1'b0; if1.tx_data = '0;
    if2.tx_valid = 1'b0; if2.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd1", 32'(txd1), 1);
    chk("rst_ready1", 32'(if1.tx_ready), 1);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    chk("rst_txd2", 32'(txd2), 1);
    reset = 1'b0;
    en1 = 1'b1;
    en2 = 1'b1;
    @(negedge clk);

    // Single byte 0x55, cycle-exact waveform
    @(negedge clk);
    if1.tx_valid = 1'b1; if1.tx_data = 8'h55;
    @(negedge clk);
    if1.tx_valid = 1'b0;
    chk("t1_cnt_after_push", 32'(cnt1), 1);
    chk("t1_txd_before_pop", 32'(txd1), 1);
    check_frame("t1", 1'b0, 8'h55, 1);

    // Loopback of "HI\n", back-to-back frames
    repeat (5) @(negedge clk);
    rx_q.delete(); start_q.delete(); rx_ferr = 0;
    pq = '{8'h48, 8'h49, 8'h0A};
    push_pq();
    wait_rx("t2", 3, 600);
    repeat (10) @(negedge clk);
    if (rx_q.size() >= 3 && start_q.size() >= 3) begin
      chk("t2_b0", 32'(rx_q[0]), 32'h48);
      chk("t2_b1", 32'(rx_q[1]), 32'h49);
      chk("t2_b2", 32'(rx_q[2]), 32'h0A);
      chk("t2_gap01", start_q[1] - start_q[0], 100);
      chk("t2_gap12", start_q[2] - start_q[1], 100);
    end
    chk("t2_ferr", rx_ferr, 0);
    chk("t2_busy_end", 32'(busy1), 0);

    // Full FIFO with en=0
    en1 = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15) chk("t3_ready_at15", 32'(if1.tx_ready), 1);
      if (i == 16) chk("t3_ready_at16", 32'(if1.tx_ready), 0);
      if1.tx_valid = 1'b1;
      if1.tx_data  = 8'(8'h10 + i);
    end
    @(negedge clk);
    if1.tx_valid = 1'b0;
    chk("t3_cnt_full", 32'(cnt1), 16);
    chk("t3_ready_full", 32'(if1.tx_ready), 0);
    repeat (20) @(negedge clk);
    chk("t3_idle_en0", 32'(busy1), 0);
    en1 = 1'b1;
    wait_rx("t3", 16, 1900);
    repeat (150) @(negedge clk);
    chk("t3_nframes", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      chk($sformatf("t3_b%0d", i), 32'(rx_q[i]), 32'h10 + i);
    chk("t3_cnt_drained", 32'(cnt1), 0);
    chk("t3_ready_drained", 32'(if1.tx_ready), 1);

    // Enable dropped during DATA of frame 1
    rx_q.delete();
    pq = '{8'h3C, 8'hC3};
    push_pq();
    repeat (30) @(negedge clk);
    chk("t4_busy_data", 32'(busy1), 1);
    en1 = 1'b0;
    wait_rx("t4a", 1, 300);
    repeat (40) @(negedge clk);
    if (rx_q.size() >= 1) chk("t4_b0", 32'(rx_q[0]), 32'h3C);
    chk("t4_cnt_hold", 32'(cnt1), 1);
    chk("t4_txd_hold", 32'(txd1), 1);
    chk("t4_busy_hold", 32'(busy1), 0);
    chk("t4_nframes_hold", rx_q.size(), 1);
    en1 = 1'b1;
    @(negedge clk);
    chk("t4_restart_txd", 32'(txd1), 0);
    chk("t4_restart_busy", 32'(busy1), 1);
    wait_rx("t4b", 2, 300);
    repeat (20) @(negedge clk);
    if (rx_q.size() >= 2) chk("t4_b1", 32'(rx_q[1]), 32'hC3);
    chk("t4_cnt_end", 32'(cnt1), 0);

    // Reset during DATA with 3 bytes queued
    pq = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_pq();
    repeat (30) @(negedge clk);
    chk("t5_cnt_pre", 32'(cnt1), 3);
    chk("t5_busy_pre", 32'(busy1), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_txd", 32'(txd1), 1);
    chk("t5_busy", 32'(busy1), 0);
    chk("t5_cnt", 32'(cnt1), 0);
    chk("t5_ready", 32'(if1.tx_ready), 1);
    lows = 0;
    repeat (300) @(negedge clk) if (txd1 !== 1'b1) lows++;
    chk("t5_no_frames", lows, 0);
    chk("t5_busy_after", 32'(busy1), 0);

    // Two stop bits, 0xA3
    @(negedge clk);
    if2.tx_valid = 1'b1; if2.tx_data = 8'hA3;
    @(negedge clk);
    if2.tx_valid = 1'b0;
    chk("t6_cnt_after_push", 32'(cnt2), 1);
    check_frame("t6", 1'b1, 8'hA3, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
